// File: rtl/news_phase_scheduler_if.sv
// Sensor-request / light-output bundle between the intersection scheduler and its neighbours.
// master: sensor side driving req; slave: the scheduler driving lights and status.
interface news_phase_scheduler_if;
    logic [3:0] req;
    logic [1:0] light_n;
    logic [1:0] light_e;
    logic [1:0] light_w;
    logic [1:0] light_s;
    logic [3:0] grant;
    logic [1:0] phase;
    logic [3:0] pending;

    modport master (
        output req,
        input  light_n, light_e, light_w, light_s, grant, phase, pending
    );

    modport slave (
        input  req,
        output light_n, light_e, light_w, light_s, grant, phase, pending
    );
endinterface

// File: rtl/news_phase_scheduler.sv
// Four-approach round-robin green scheduler with min/max green, yellow and all-red timing.
// Outputs are decoded from state/owner registers only, so they move on the state edge.
module news_phase_scheduler #(
    parameter int MIN_GREEN = 30,
    parameter int MAX_GREEN = 55,
    parameter int YELLOW_T  = 5,
    parameter int ALLRED_T  = 2,
    parameter int CNT_W     = 8
) (
    input  logic                  clk,
    input  logic                  clear_n,
    news_phase_scheduler_if.slave bus
);
    typedef enum logic [1:0] {
        ALLRED = 2'd0,
        GREEN  = 2'd1,
        YELLOW = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] AR_END  = CNT_W'(ALLRED_T - 1);
    localparam logic [CNT_W-1:0] MIN_END = CNT_W'(MIN_GREEN - 1);
    localparam logic [CNT_W-1:0] MAX_END = CNT_W'(MAX_GREEN - 1);
    localparam logic [CNT_W-1:0] Y_END   = CNT_W'(YELLOW_T - 1);
    localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);

    state_t           state, state_nxt;
    logic [CNT_W-1:0] timer, timer_nxt;
    logic [3:0]       pending, pending_nxt;
    logic [1:0]       last, last_nxt;   // doubles as the current owner while not ALLRED
    logic [3:0]       owner_oh, grant_clr, set_mask;
    logic [1:0]       winner;
    logic             others;

    assign owner_oh = 4'b0001 << last;
    assign others   = |(pending & ~owner_oh);

    // Scan from last+4 (= last, lowest priority) down to last+1 so the nearest successor wins.
    always_comb begin
        logic [1:0] idx;
        winner = last;
        for (int k = 4; k >= 1; k--) begin
            idx = last + 2'(k);
            if (pending[idx]) winner = idx;
        end
    end

    always_comb begin
        state_nxt = state;
        timer_nxt = timer;
        last_nxt  = last;
        grant_clr = 4'b0000;
        case (state)
            ALLRED: begin
                if (timer >= AR_END) begin
                    if (|pending) begin
                        state_nxt = GREEN;
                        last_nxt  = winner;
                        timer_nxt = '0;
                        grant_clr = 4'b0001 << winner;
                    end
                end else begin
                    timer_nxt = timer + ONE;
                end
            end
            GREEN: begin
                if (timer >= MIN_END && others && (!bus.req[last] || timer >= MAX_END)) begin
                    state_nxt = YELLOW;
                    timer_nxt = '0;
                end else if (timer < MAX_END) begin
                    timer_nxt = timer + ONE;
                end
            end
            YELLOW: begin
                if (timer >= Y_END) begin
                    state_nxt = ALLRED;
                    timer_nxt = '0;
                end else begin
                    timer_nxt = timer + ONE;
                end
            end
            default: begin
                state_nxt = ALLRED;
                timer_nxt = '0;
            end
        endcase
    end

    // The green owner's own request is ignored; clear on grant beats a same-edge set.
    assign set_mask    = (state == GREEN) ? ~owner_oh : 4'b1111;
    assign pending_nxt = (pending | (bus.req & set_mask)) & ~grant_clr;

    always_ff @(posedge clk or negedge clear_n) begin
        if (!clear_n) begin
            state   <= ALLRED;
            timer   <= '0;
            pending <= '0;
            last    <= 2'd3;
        end else begin
            state   <= state_nxt;
            timer   <= timer_nxt;
            pending <= pending_nxt;
            last    <= last_nxt;
        end
    end

    logic [3:0][1:0] lights;
    logic [1:0]      phase_code;
    logic            active;

    always_comb begin
        phase_code = 2'd0;
        case (state)
            GREEN:   phase_code = 2'd1;
            YELLOW:  phase_code = 2'd2;
            default: phase_code = 2'd0;
        endcase
    end

    assign active = (state == GREEN) || (state == YELLOW);

    always_comb begin
        for (int i = 0; i < 4; i++) begin
            lights[i] = 2'd0;
            if (active && last == 2'(i))
                lights[i] = (state == GREEN) ? 2'd2 : 2'd1;
        end
    end

    assign bus.light_n = lights[0];
    assign bus.light_e = lights[1];
    assign bus.light_w = lights[2];
    assign bus.light_s = lights[3];
    assign bus.grant   = active ? owner_oh : 4'b0000;
    assign bus.phase   = phase_code;
    assign bus.pending = pending;
endmodule

// File: tb/tb_news_phase_scheduler.sv
// Directed bench for news_phase_scheduler: table of per-cycle vectors plus hand sequences.
module tb_news_phase_scheduler;
    logic clk = 1'b0;
    logic clear_n;
    int   checks = 0;
    int   failures = 0;

    news_phase_scheduler_if bus ();

    news_phase_scheduler #(
        .MIN_GREEN(4), .MAX_GREEN(10), .YELLOW_T(2), .ALLRED_T(1), .CNT_W(8)
    ) dut (
        .clk     (clk),
        .clear_n (clear_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] req;
        logic [7:0] lights;   // {s, w, e, n}
        logic [3:0] grant;
        logic [1:0] phase;
        logic [3:0] pending;
    } vec_t;

    vec_t vecs[$];

    function automatic logic [7:0] lts(input logic [3:0] g, input logic [1:0] code);
        logic [7:0] r;
        r = 8'h00;
        for (int i = 0; i < 4; i++)
            if (g[i]) r[2*i +: 2] = code;
        return r;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [7:0] el, input logic [3:0] eg,
                         input logic [1:0] ep, input logic [3:0] epend);
        logic [17:0] got, exp;
        got = {bus.light_s, bus.light_w, bus.light_e, bus.light_n, bus.grant, bus.phase, bus.pending};
        exp = {el, eg, ep, epend};
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s t=%0t lights/grant/phase/pending got=%h exp=%h", name, $time, got, exp);
        end
    endtask

    task automatic do_reset();
        bus.req = 4'h0;
        clear_n = 1'b0;
        tick();
        tick();
        clear_n = 1'b1;
    endtask

    initial begin
        logic [3:0] g, p;
        bus.req = 4'h0;
        clear_n = 1'b0;
        #3;
        check("reset_state", 8'h00, 4'h0, 2'd0, 4'h0);
        tick();
        clear_n = 1'b1;

        // Idle after reset
        for (int i = 0; i < 50; i++) begin
            tick();
            check("idle", 8'h00, 4'h0, 2'd0, 4'h0);
        end

        // Single E pulse, E rests green with no competition
        do_reset();
        bus.req = 4'b0010;
        tick();
        check("e_pulse_pending", 8'h00, 4'h0, 2'd0, 4'b0010);
        bus.req = 4'h0;
        tick();
        check("e_grant", lts(4'b0010, 2'd2), 4'b0010, 2'd1, 4'h0);
        for (int i = 0; i < 40; i++) begin
            tick();
            check("e_rest_green", lts(4'b0010, 2'd2), 4'b0010, 2'd1, 4'h0);
        end

        // N held, W pulsed: N runs to MAX_GREEN
        do_reset();
        bus.req = 4'b0001;
        tick();
        tick();
        check("n_max_g1", lts(4'b0001, 2'd2), 4'b0001, 2'd1, 4'h0);
        bus.req = 4'b0101;
        tick();
        bus.req = 4'b0001;
        check("n_max_g2", lts(4'b0001, 2'd2), 4'b0001, 2'd1, 4'b0100);
        for (int i = 3; i <= 10; i++) begin
            tick();
            check("n_max_green", lts(4'b0001, 2'd2), 4'b0001, 2'd1, 4'b0100);
        end
        tick();
        check("n_max_y1", lts(4'b0001, 2'd1), 4'b0001, 2'd2, 4'b0100);
        tick();
        check("n_max_y2", lts(4'b0001, 2'd1), 4'b0001, 2'd2, 4'b0101);
        tick();
        check("n_max_allred", 8'h00, 4'h0, 2'd0, 4'b0101);
        tick();
        check("w_green", lts(4'b0100, 2'd2), 4'b0100, 2'd2 - 2'd1, 4'b0001);

        // N dropped at cycle 1, E pulsed: N runs MIN_GREEN
        do_reset();
        bus.req = 4'b0001;
        tick();
        tick();
        check("n_min_g1", lts(4'b0001, 2'd2), 4'b0001, 2'd1, 4'h0);
        bus.req = 4'b0010;
        tick();
        bus.req = 4'h0;
        check("n_min_g2", lts(4'b0001, 2'd2), 4'b0001, 2'd1, 4'b0010);
        tick();
        check("n_min_g3", lts(4'b0001, 2'd2), 4'b0001, 2'd1, 4'b0010);
        tick();
        check("n_min_g4", lts(4'b0001, 2'd2), 4'b0001, 2'd1, 4'b0010);
        tick();
        check("n_min_y1", lts(4'b0001, 2'd1), 4'b0001, 2'd2, 4'b0010);
        tick();
        check("n_min_y2", lts(4'b0001, 2'd1), 4'b0001, 2'd2, 4'b0010);
        tick();
        check("n_min_allred", 8'h00, 4'h0, 2'd0, 4'b0010);
        tick();
        check("n_min_e_green", lts(4'b0010, 2'd2), 4'b0010, 2'd1, 4'h0);

        // All four pulsed once: round-robin N, E, W, S, table-driven
        vecs.push_back('{4'hf, 8'h00, 4'h0, 2'd0, 4'hf});
        for (int k = 0; k < 4; k++) begin
            g = 4'b0001 << k;
            p = 4'hf << (k + 1);
            for (int c = 0; c < 4; c++) vecs.push_back('{4'h0, lts(g, 2'd2), g, 2'd1, p});
            if (k < 3) begin
                for (int c = 0; c < 2; c++) vecs.push_back('{4'h0, lts(g, 2'd1), g, 2'd2, p});
                vecs.push_back('{4'h0, 8'h00, 4'h0, 2'd0, p});
            end
        end
        for (int c = 0; c < 3; c++) vecs.push_back('{4'h0, lts(4'b1000, 2'd2), 4'b1000, 2'd1, 4'h0});
        do_reset();
        foreach (vecs[i]) begin
            bus.req = vecs[i].req;
            tick();
            check("rr_vec", vecs[i].lights, vecs[i].grant, vecs[i].phase, vecs[i].pending);
        end

        // Asynchronous clear in the middle of E yellow with W pending
        do_reset();
        bus.req = 4'b0010;
        tick();
        bus.req = 4'h0;
        tick();
        check("clr_e_g1", lts(4'b0010, 2'd2), 4'b0010, 2'd1, 4'h0);
        bus.req = 4'b0100;
        tick();
        bus.req = 4'h0;
        tick();
        tick();
        check("clr_e_g4", lts(4'b0010, 2'd2), 4'b0010, 2'd1, 4'b0100);
        tick();
        check("clr_e_y1", lts(4'b0010, 2'd1), 4'b0010, 2'd2, 4'b0100);
        #2;
        clear_n = 1'b0;
        #1;
        check("clr_immediate", 8'h00, 4'h0, 2'd0, 4'h0);
        tick();
        tick();
        check("clr_held", 8'h00, 4'h0, 2'd0, 4'h0);
        clear_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            check("clr_rest", 8'h00, 4'h0, 2'd0, 4'h0);
        end
        bus.req = 4'b1000;
        tick();
        check("clr_new_pending", 8'h00, 4'h0, 2'd0, 4'b1000);
        bus.req = 4'h0;
        tick();
        check("clr_s_green", lts(4'b1000, 2'd2), 4'b1000, 2'd1, 4'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
